// File: rtl/stage_mem.sv
// Memory-access pipeline stage: runs a req/ack data-memory transaction for loads and
// stores, aligns store data, extends load data and emits one writeback record per instruction.
module stage_mem #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_SIZE = 5,
  parameter int unsigned FUNCT3_SIZE    = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic [INSTR_REG_SIZE-1:0] rd_i,
  input  logic                      ctrl_ld_i,
  input  logic                      ctrl_st_i,
  input  logic                      ctrl_reg_write_i,
  input  logic [FUNCT3_SIZE-1:0]    ctrl_mem_width_i,
  output logic                      stall_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [WD_SIZE-1:0]        mem_addr_o,
  output logic [WD_SIZE/8-1:0]      mem_be_o,
  output logic [WD_SIZE-1:0]        mem_wdata_o,
  input  logic                      mem_ack_i,
  input  logic [WD_SIZE-1:0]        mem_rdata_i,
  output logic [INSTR_REG_SIZE-1:0] rd_o,
  output logic                      ctrl_reg_write_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic                      mem_err_o
);

  localparam int unsigned BE_W = WD_SIZE / 8;

  localparam logic [FUNCT3_SIZE-1:0] F3_B  = FUNCT3_SIZE'(0);
  localparam logic [FUNCT3_SIZE-1:0] F3_H  = FUNCT3_SIZE'(1);
  localparam logic [FUNCT3_SIZE-1:0] F3_W  = FUNCT3_SIZE'(2);
  localparam logic [FUNCT3_SIZE-1:0] F3_BU = FUNCT3_SIZE'(4);
  localparam logic [FUNCT3_SIZE-1:0] F3_HU = FUNCT3_SIZE'(5);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t state_q, state_d;

  // Request latched on entry to ACCESS
  logic [WD_SIZE-1:0]        addr_q;
  logic [1:0]                off_q;
  logic [FUNCT3_SIZE-1:0]    width_q;
  logic [INSTR_REG_SIZE-1:0] rd_q;
  logic                      we_q;
  logic [BE_W-1:0]           be_q;
  logic [WD_SIZE-1:0]        wdata_q;

  logic                      lat_en;
  logic [INSTR_REG_SIZE-1:0] rd_d;
  logic                      rw_d;
  logic [WD_SIZE-1:0]        wb_d;
  logic                      err_d;

  logic [1:0]                off;
  logic                      mem_op;
  logic                      width_ok;
  logic                      aligned;
  logic                      is_unsigned;
  logic                      legal;
  logic [BE_W-1:0]           be_new;
  logic [WD_SIZE-1:0]        wdata_new;
  logic [WD_SIZE-1:0]        rdata_shift;
  logic [WD_SIZE-1:0]        ld_data;

  // Decode width, alignment and legality of the incoming instruction
  always_comb begin
    off         = alu_result_i[1:0];
    mem_op      = ctrl_ld_i | ctrl_st_i;
    width_ok    = 1'b1;
    aligned     = 1'b1;
    is_unsigned = 1'b0;
    be_new      = '1;
    wdata_new   = rs2_data_i;
    case (ctrl_mem_width_i)
      F3_B, F3_BU: begin
        is_unsigned = (ctrl_mem_width_i == F3_BU);
        be_new      = BE_W'(1) << off;
        wdata_new   = {BE_W{rs2_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        is_unsigned = (ctrl_mem_width_i == F3_HU);
        aligned     = ~off[0];
        be_new      = BE_W'(3) << off;
        wdata_new   = {(BE_W/2){rs2_data_i[15:0]}};
      end
      F3_W: begin
        aligned = (off == 2'b00);
      end
      default: width_ok = 1'b0;
    endcase
    if (!ctrl_st_i) be_new = '1;
    legal = width_ok & aligned & ~(ctrl_ld_i & ctrl_st_i) & ~(ctrl_st_i & is_unsigned);
  end

  // Load data extraction from the latched lane offset
  always_comb begin
    rdata_shift = mem_rdata_i >> {off_q, 3'b000};
    case (width_q)
      F3_B:    ld_data = {{(WD_SIZE-8){rdata_shift[7]}}, rdata_shift[7:0]};
      F3_BU:   ld_data = {{(WD_SIZE-8){1'b0}}, rdata_shift[7:0]};
      F3_H:    ld_data = {{(WD_SIZE-16){rdata_shift[15]}}, rdata_shift[15:0]};
      F3_HU:   ld_data = {{(WD_SIZE-16){1'b0}}, rdata_shift[15:0]};
      default: ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, handshake outputs and next writeback record
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    lat_en    = 1'b0;
    rd_d      = rd_o;
    rw_d      = 1'b0;
    wb_d      = wb_data_o;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (legal) begin
            stall_o = 1'b1;
            lat_en  = 1'b1;
            state_d = ACCESS;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          rd_d = rd_i;
          rw_d = ctrl_reg_write_i;
          wb_d = alu_result_i;
        end
      end
      ACCESS: begin
        mem_req_o = 1'b1;
        stall_o   = ~mem_ack_i;
        if (mem_ack_i) begin
          state_d = IDLE;
          rd_d    = rd_q;
          rw_d    = ~we_q;
          if (!we_q) wb_d = ld_data;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset_n) begin
      stall_o   = 1'b0;
      mem_req_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_o             <= '0;
      ctrl_reg_write_o <= 1'b0;
      wb_data_o        <= '0;
      mem_err_o        <= 1'b0;
      addr_q           <= '0;
      off_q            <= '0;
      width_q          <= '0;
      rd_q             <= '0;
      we_q             <= 1'b0;
      be_q             <= '0;
      wdata_q          <= '0;
    end else begin
      rd_o             <= rd_d;
      ctrl_reg_write_o <= rw_d;
      wb_data_o        <= wb_d;
      mem_err_o        <= err_d;
      if (lat_en) begin
        addr_q  <= {alu_result_i[WD_SIZE-1:2], 2'b00};
        off_q   <= off;
        width_q <= ctrl_mem_width_i;
        rd_q    <= rd_i;
        we_q    <= ctrl_st_i;
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule
